tqvp_sample_pacer: RTL and testbench

//   Upstream acquisition stage for the moving-average FIR peripheral.
//   - Samples ui_in at a programmable period and buffers the samples in a small FIFO.
//   - Delivers the samples on a valid/ready stream, so the filter consumes evenly spaced

---
 rtl/tqvp_sample_pacer.sv | 109 ++++++++++
 tb/tb_tqvp_sample_pacer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_sample_pacer.sv
// Sample pacer: captures ui_in at a programmable period into a small FIFO and
// streams the buffered samples out on a valid/ready interface.
module tqvp_sample_pacer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [7:0] sample_out,
   output logic       sample_valid,
   input  logic       sample_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic          r_en;
   logic [15:0]   r_div;
   logic [15:0]   r_cnt;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic          w_ctrl_wr;
   logic          w_clr;
   logic          w_trig;
   logic          w_tick;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_ovf_set;
   logic [7:0]    w_status;

   assign w_ctrl_wr  = data_write && (address == 4'h0);
   assign w_clr      = w_ctrl_wr && data_in[1];
   assign w_trig     = w_ctrl_wr && data_in[2];
   assign w_tick     = r_en && (r_cnt == '0);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));

   // CLR wins over everything; a pop frees the slot a same-cycle push needs when full.
   assign w_pop      = !w_clr && !w_empty &&
                       ((sample_valid && sample_ready) || (data_write && (address == 4'h4)));
   assign w_push_req = !w_clr && (w_tick || w_trig);
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;

   assign sample_valid = !w_empty;
   assign sample_out   = w_empty ? '0 : r_mem[r_rp];
   assign w_status     = {r_en, r_ovf, w_full, w_empty, 4'(r_count)};

   always_comb begin
      data_out = '0;
      case (address)
         4'h0:    data_out = {7'b0, r_en};
         4'h1:    data_out = r_div[7:0];
         4'h2:    data_out = r_div[15:8];
         4'h3:    data_out = w_status;
         4'h4:    data_out = sample_out;
         default: data_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en    <= 1'b0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_ctrl_wr)                         r_en        <= data_in[0];
         if (data_write && (address == 4'h1))   r_div[7:0]  <= data_in;
         if (data_write && (address == 4'h2))   r_div[15:8] <= data_in;

         // Held at DIV while disabled, so the first tick lands DIV+1 clocks after enabling.
         if (w_clr || !r_en || w_tick) r_cnt <= r_div;
         else                          r_cnt <= r_cnt - 1'b1;

         if (w_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
         end else begin
            if (w_push)    r_wp  <= r_wp + 1'b1;
            if (w_pop)     r_rp  <= r_rp + 1'b1;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= ui_in;
   end

endmodule

// File: tb/tb_tqvp_sample_pacer.sv
// Scoreboard bench for tqvp_sample_pacer: an event-time reference model predicts
// captures; a negedge monitor checks stream pops and register reads against it.
module tb_tqvp_sample_pacer;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] sample_out;
   logic       sample_valid;
   logic       sample_ready;

   tqvp_sample_pacer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ui_in        (ui_in),
      .address      (address),
      .data_write   (data_write),
      .data_in      (data_in),
      .data_out     (data_out),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the FIFO is a plain queue; ticks are predicted as absolute edge numbers.
   byte unsigned q[$];
   bit           m_en  = 1'b0;
   bit           m_ovf = 1'b0;
   logic [15:0]  m_div = '0;
   longint       edge_no   = 0;
   longint       next_tick = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_status();
      int n = q.size();
      return {24'b0, m_en, m_ovf, (n == DEPTH), (n == 0), 4'(n)};
   endfunction

   // Capture prediction, evaluated with the inputs presented for the cycle ending at this edge.
   always @(posedge clk) begin
      bit tick, clr, trig, wr;
      logic [3:0] a;
      logic [7:0] d;
      edge_no++;
      if (rst_n) begin
         wr   = data_write;
         a    = address;
         d    = data_in;
         clr  = wr && (a == 4'h0) && d[1];
         trig = wr && (a == 4'h0) && d[2];
         tick = m_en && (edge_no == next_tick);
         if (tick) next_tick = edge_no + longint'(m_div) + 1;
         if (clr) begin
            q.delete();
            m_ovf     = 1'b0;
            next_tick = edge_no + longint'(m_div) + 1;
         end else if (tick || trig) begin
            if (q.size() < DEPTH) q.push_back(ui_in);
            else                  m_ovf = 1'b1;
         end
         if (wr && (a == 4'h0)) begin
            if (!m_en && d[0]) next_tick = edge_no + longint'(m_div) + 1;
            m_en = d[0];
         end
         if (wr && (a == 4'h1)) m_div[7:0]  = d;
         if (wr && (a == 4'h2)) m_div[15:8] = d;
      end
   end

   // Monitor: compares outputs against the model, then retires whatever the DUT pops.
   always @(negedge clk) begin
      if (rst_n) begin
         check("sample_valid", int'(sample_valid), int'(q.size() != 0));
         if (q.size() != 0) check("sample_out", int'(sample_out), int'(q[0]));
         case (address)
            4'h0:    check("rd_ctrl",   int'(data_out), int'(m_en));
            4'h1:    check("rd_div_lo", int'(data_out), int'(m_div[7:0]));
            4'h2:    check("rd_div_hi", int'(data_out), int'(m_div[15:8]));
            4'h3:    check("rd_status", int'(data_out), exp_status());
            4'h4:    check("rd_data",   int'(data_out), (q.size() != 0) ? int'(q[0]) : 0);
            default: check("rd_unmapped", int'(data_out), 0);
         endcase
         if (q.size() != 0 && !(data_write && address == 4'h0 && data_in[1]) &&
             (sample_ready || (data_write && address == 4'h4)))
            void'(q.pop_front());
      end
   end

   task automatic cyc(input bit wr, input logic [3:0] a, input logic [7:0] d,
                      input bit rdy, input logic [7:0] u);
      data_write   = wr;
      address      = a;
      data_in      = d;
      sample_ready = rdy;
      ui_in        = u;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      q.delete();
      m_en  = 1'b0;
      m_ovf = 1'b0;
      m_div = '0;
      data_write = 1'b0;
      address    = 4'h3;
      #1;
      check("rst_valid",  int'(sample_valid), 0);
      check("rst_status", int'(data_out), 8'h10);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      data_write = 1'b0; address = 4'h3; data_in = '0; sample_ready = 1'b0; ui_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_status", int'(data_out), 8'h10);
      check("reset_valid",  int'(sample_valid), 0);
      check("reset_out",    int'(sample_out), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b0, 4'(i), 8'h00, 1'b0, 8'h00);

      // Periodic capture with DIV=3 and a free-flowing consumer.
      cyc(1'b1, 4'h1, 8'd3, 1'b1, 8'h00);
      cyc(1'b1, 4'h0, 8'h01, 1'b1, 8'h0F);
      for (int i = 0; i < 20; i++) cyc(1'b0, 4'h3, 8'h00, 1'b1, 8'(8'h10 + i));
      cyc(1'b1, 4'h0, 8'h00, 1'b1, 8'h50);
      for (int i = 0; i < 8; i++) cyc(1'b0, 4'h4, 8'h00, 1'b1, 8'h51);

      // DIV=0 with a stalled consumer: fill, then overflow.
      cyc(1'b1, 4'h1, 8'd0, 1'b0, 8'h00);
      cyc(1'b1, 4'h0, 8'h01, 1'b0, 8'h1F);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'h3, 8'h00, 1'b0, 8'(8'h20 + i));
      check("full_ovf_status", int'(data_out), 8'hE4);

      // Full FIFO, consumer ready on a tick: count stays at DEPTH without overflow.
      cyc(1'b1, 4'h0, 8'h03, 1'b0, 8'h30);
      for (int i = 0; i < 4; i++) cyc(1'b0, 4'h3, 8'h00, 1'b0, 8'(8'h31 + i));
      cyc(1'b0, 4'h3, 8'h00, 1'b1, 8'h40);
      check("full_pop_push_status", int'(data_out), 8'hA4);
      cyc(1'b1, 4'h0, 8'h02, 1'b0, 8'h41);

      // Manual trigger while disabled, then DATA-write pop.
      cyc(1'b1, 4'h0, 8'h04, 1'b0, 8'hA5);
      check("trig_out", int'(sample_out), 8'hA5);
      cyc(1'b1, 4'h4, 8'h00, 1'b0, 8'h00);
      address = 4'h3; #1;
      check("trig_pop_status", int'(data_out), 8'h10);

      // CLR during a tick with two entries held and OVF set.
      cyc(1'b1, 4'h0, 8'h01, 1'b0, 8'h60);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'h3, 8'h00, 1'b0, 8'(8'h61 + i));
      cyc(1'b1, 4'h0, 8'h00, 1'b0, 8'h70);
      cyc(1'b1, 4'h4, 8'h00, 1'b0, 8'h71);
      cyc(1'b1, 4'h4, 8'h00, 1'b0, 8'h72);
      cyc(1'b1, 4'h0, 8'h01, 1'b0, 8'h73);
      cyc(1'b1, 4'h0, 8'h03, 1'b0, 8'h74);
      address = 4'h3; #1;
      check("clr_status", int'(data_out), 8'h90);

      // Mid-stream asynchronous reset.
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'h3, 8'h00, 1'b0, 8'(8'h80 + i));
      do_reset();

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         int r;
         bit wr;
         logic [3:0] a;
         logic [7:0] d;
         r  = int'($urandom_range(0, 99));
         wr = 1'b0;
         a  = 4'($urandom_range(0, 15));
         d  = 8'($urandom);
         if (r < 4) begin
            wr = 1'b1; a = 4'h0;
            d = {5'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0)};
         end else if (r < 6) begin
            wr = 1'b1; a = 4'h1; d = 8'($urandom_range(0, 7));
         end else if (r < 7) begin
            wr = 1'b1; a = 4'h2; d = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
         end else if (r < 12) begin
            wr = 1'b1; a = 4'h4;
         end else if (r < 13) begin
            wr = 1'b1; a = 4'($urandom_range(5, 15));
         end
         if (i == 700) do_reset();
         cyc(wr, a, d, ($urandom_range(0, 2) != 0), 8'($urandom));
      end

      cyc(1'b0, 4'h3, 8'h00, 1'b0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
